// File: rtl/snd_cmd_if.sv
// 68000 -> Z80 sound command latch, Z80 IRQ on SNDON rising edge, fractional 3.58 MHz clock enable.
// Define SND_CMD_FIFO_EN to replace the single command latch with a 4-deep FIFO.
module snd_cmd_if #(
    parameter int CE_NUM = 179,
    parameter int CE_DEN = 1200,
    parameter int ACC_W  = 11
) (
    input  logic       clk_main,
    input  logic       nRESET,
    input  logic       SNDDT,
    input  logic       SNDON,
    input  logic [7:0] m68k_dout_lo,
    input  logic       z80_m1_n,
    input  logic       z80_iorq_n,
    input  logic       z80_cmd_rd_n,
    output logic       z80_ce,
    output logic [7:0] z80_cmd,
    output logic       z80_int_n,
    output logic       cmd_pending,
    output logic       cmd_overrun
);

    logic [ACC_W-1:0] acc_q, acc_d, sum;
    logic             ce_q, ce_d;
    logic             snddt_dly_q, sndon_dly_q, rd_dly_q;
    logic [7:0]       cmd_q, cmd_d;
    logic             irq_q, irq_d;
    logic             int_n_q, int_n_d;
    logic             pend_q, pend_d;
    logic             ovr_q, ovr_d;
    logic             wr_edge, rd_edge, son_rise, iack;

`ifdef SND_CMD_FIFO_EN
    logic [7:0] mem_q [4];
    logic [7:0] mem_d [4];
    logic [1:0] rp_q, rp_d, wp_q, wp_d;
    logic [2:0] cnt_q, cnt_d;
    logic       do_push, do_pop;
`endif

    always_comb begin
        sum      = acc_q + ACC_W'(CE_NUM);
        acc_d    = sum;
        ce_d     = 1'b0;
        if (sum >= ACC_W'(CE_DEN)) begin
            acc_d = sum - ACC_W'(CE_DEN);
            ce_d  = 1'b1;
        end

        wr_edge  = snddt_dly_q & ~SNDDT;
        rd_edge  = rd_dly_q & ~z80_cmd_rd_n;
        son_rise = ~sndon_dly_q & SNDON;
        // IACK is qualified by the enable the Z80 is actually running on this cycle
        iack     = ce_q & ~z80_m1_n & ~z80_iorq_n;

        irq_d    = son_rise ? 1'b1 : (iack ? 1'b0 : irq_q);
        int_n_d  = ~irq_d;

        cmd_d    = cmd_q;
        pend_d   = pend_q;
        ovr_d    = ovr_q;
`ifdef SND_CMD_FIFO_EN
        mem_d    = mem_q;
        rp_d     = rp_q;
        wp_d     = wp_q;
        cnt_d    = cnt_q;
        do_pop   = rd_edge & (cnt_q != 3'd0);
        // A full FIFO still accepts the push when a pop frees the head slot this cycle
        do_push  = wr_edge & ((cnt_q != 3'd4) | do_pop);
        if (wr_edge & ~do_push) ovr_d = 1'b1;
        if (do_pop) rp_d = rp_q + 2'd1;
        if (do_push) begin
            mem_d[wp_q] = m68k_dout_lo;
            wp_d        = wp_q + 2'd1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase
        pend_d = (cnt_d != 3'd0);
        if (cnt_d != 3'd0) cmd_d = mem_d[rp_d];
`else
        if (wr_edge) begin
            cmd_d  = m68k_dout_lo;
            pend_d = 1'b1;
            if (pend_q & ~rd_edge) ovr_d = 1'b1;
        end else if (rd_edge) begin
            pend_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk_main or negedge nRESET) begin
        if (!nRESET) begin
            acc_q       <= '0;
            ce_q        <= 1'b0;
            snddt_dly_q <= 1'b1;
            sndon_dly_q <= 1'b0;
            rd_dly_q    <= 1'b1;
            cmd_q       <= 8'h00;
            irq_q       <= 1'b0;
            int_n_q     <= 1'b1;
            pend_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            ce_q        <= ce_d;
            snddt_dly_q <= SNDDT;
            sndon_dly_q <= SNDON;
            rd_dly_q    <= z80_cmd_rd_n;
            cmd_q       <= cmd_d;
            irq_q       <= irq_d;
            int_n_q     <= int_n_d;
            pend_q      <= pend_d;
            ovr_q       <= ovr_d;
        end
    end

`ifdef SND_CMD_FIFO_EN
    always_ff @(posedge clk_main or negedge nRESET) begin
        if (!nRESET) begin
            for (int i = 0; i < 4; i++) mem_q[i] <= 8'h00;
            rp_q  <= 2'd0;
            wp_q  <= 2'd0;
            cnt_q <= 3'd0;
        end else begin
            mem_q <= mem_d;
            rp_q  <= rp_d;
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
        end
    end
`endif

    assign z80_ce      = ce_q;
    assign z80_cmd     = cmd_q;
    assign z80_int_n   = int_n_q;
    assign cmd_pending = pend_q;
    assign cmd_overrun = ovr_q;

endmodule

// File: tb/tb_snd_cmd_if.sv
// Randomized and directed bench for snd_cmd_if against a cycle-level behavioural model.
module tb_snd_cmd_if;

    logic       clk_main = 1'b0;
    logic       nRESET = 1'b0;
    logic       SNDDT = 1'b1;
    logic       SNDON = 1'b0;
    logic [7:0] m68k_dout_lo = 8'h00;
    logic       z80_m1_n = 1'b1;
    logic       z80_iorq_n = 1'b1;
    logic       z80_cmd_rd_n = 1'b1;
    logic       z80_ce;
    logic [7:0] z80_cmd;
    logic       z80_int_n;
    logic       cmd_pending;
    logic       cmd_overrun;

    int checks = 0;
    int errors = 0;

    snd_cmd_if dut (
        .clk_main     (clk_main),
        .nRESET       (nRESET),
        .SNDDT        (SNDDT),
        .SNDON        (SNDON),
        .m68k_dout_lo (m68k_dout_lo),
        .z80_m1_n     (z80_m1_n),
        .z80_iorq_n   (z80_iorq_n),
        .z80_cmd_rd_n (z80_cmd_rd_n),
        .z80_ce       (z80_ce),
        .z80_cmd      (z80_cmd),
        .z80_int_n    (z80_int_n),
        .cmd_pending  (cmd_pending),
        .cmd_overrun  (cmd_overrun)
    );

    always #5 clk_main = ~clk_main;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: pulse k of z80_ce falls where floor(n*NUM/DEN) steps.
    int         m_cnt;
    bit         m_ce, m_irq, m_pend, m_ovr;
    bit         m_prev_wr, m_prev_on, m_prev_rd;
    logic [7:0] m_cmd;
    logic [7:0] m_q[$];

    task automatic model_reset();
        m_cnt = 0; m_ce = 0; m_irq = 0; m_pend = 0; m_ovr = 0;
        m_prev_wr = 1; m_prev_on = 0; m_prev_rd = 1;
        m_cmd = 8'h00;
        m_q.delete();
    endtask

    task automatic model_tick();
        bit wr, rd, rise, ack;
        wr   = m_prev_wr && !SNDDT;
        rd   = m_prev_rd && !z80_cmd_rd_n;
        rise = !m_prev_on && SNDON;
        ack  = m_ce && !z80_m1_n && !z80_iorq_n;
        m_cnt++;
        m_ce = ((m_cnt * 179) / 1200) != (((m_cnt - 1) * 179) / 1200);
        if (rise) m_irq = 1;
        else if (ack) m_irq = 0;
`ifdef SND_CMD_FIFO_EN
        if (rd && m_q.size() > 0) void'(m_q.pop_front());
        if (wr) begin
            if (m_q.size() < 4) m_q.push_back(m68k_dout_lo);
            else m_ovr = 1;
        end
        m_pend = (m_q.size() != 0);
        if (m_pend) m_cmd = m_q[0];
`else
        if (wr) begin
            if (m_pend && !rd) m_ovr = 1;
            m_cmd  = m68k_dout_lo;
            m_pend = 1;
        end else if (rd) begin
            m_pend = 0;
        end
`endif
        m_prev_wr = SNDDT;
        m_prev_on = SNDON;
        m_prev_rd = z80_cmd_rd_n;
    endtask

    task automatic step();
        model_tick();
        @(posedge clk_main);
        #1;
        check("ce", z80_ce, m_ce);
        check("cmd", z80_cmd, m_cmd);
        check("int_n", z80_int_n, !m_irq);
        check("pending", cmd_pending, m_pend);
        check("overrun", cmd_overrun, m_ovr);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ce"}, z80_ce, 0);
        check({tag, "_cmd"}, z80_cmd, 8'h00);
        check({tag, "_int_n"}, z80_int_n, 1);
        check({tag, "_pend"}, cmd_pending, 0);
        check({tag, "_ovr"}, cmd_overrun, 0);
    endtask

    task automatic idle_inputs();
        SNDDT = 1; SNDON = 0; z80_cmd_rd_n = 1; z80_m1_n = 1; z80_iorq_n = 1;
    endtask

    task automatic write_cmd(input logic [7:0] d);
        m68k_dout_lo = d; SNDDT = 0;
        step();
        SNDDT = 1;
        step();
    endtask

    // Advance until the current cycle's z80_ce equals want; bounded.
    task automatic wait_ce(input bit want);
        int n = 0;
        while (z80_ce !== want && n < 20) begin
            step();
            n++;
        end
        check("ce_wait", z80_ce, want);
    endtask

    initial begin
        int pulses, adj;
        bit prev;
        model_reset();
        idle_inputs();
        repeat (3) @(posedge clk_main);
        #1;
        check_reset_vals("rst");
        nRESET = 1;

        pulses = 0; adj = 0; prev = 0;
        for (int i = 0; i < 1200; i++) begin
            step();
            if (z80_ce) pulses++;
            if (z80_ce && prev) adj++;
            prev = z80_ce;
        end
        check("ce_count", pulses, 179);
        check("ce_adjacent", adj, 0);
        check("idle_int_n", z80_int_n, 1);
        check("idle_cmd", z80_cmd, 8'h00);

`ifndef SND_CMD_FIFO_EN
        m68k_dout_lo = 8'h5A; SNDDT = 0;
        step();
        check("wr1_cmd", z80_cmd, 8'h5A);
        check("wr1_pend", cmd_pending, 1);
        step(); step();
        SNDDT = 1;
        step();
        check("wr1_noovr", cmd_overrun, 0);
        write_cmd(8'h33);
        check("wr2_cmd", z80_cmd, 8'h33);
        check("wr2_ovr", cmd_overrun, 1);

        write_cmd(8'h12);
        z80_cmd_rd_n = 0;
        step();
        check("rd_pend", cmd_pending, 0);
        check("rd_cmd", z80_cmd, 8'h12);
        z80_cmd_rd_n = 1;
        step();
        m68k_dout_lo = 8'h77; SNDDT = 0; z80_cmd_rd_n = 0;
        step();
        check("wrrd_pend", cmd_pending, 1);
        check("wrrd_cmd", z80_cmd, 8'h77);
        SNDDT = 1; z80_cmd_rd_n = 1;
        step();
`else
        for (int i = 1; i <= 5; i++) write_cmd(8'(i));
        check("fifo_ovr", cmd_overrun, 1);
        for (int i = 1; i <= 4; i++) begin
            check("fifo_head", z80_cmd, i);
            z80_cmd_rd_n = 0;
            step();
            z80_cmd_rd_n = 1;
            step();
        end
        check("fifo_empty", cmd_pending, 0);
        check("fifo_hold", z80_cmd, 8'h04);
        write_cmd(8'hA1);
        write_cmd(8'hA2);
`endif

        SNDON = 1;
        step();
        check("irq_set", z80_int_n, 0);
        repeat (3) step();
        check("irq_hold", z80_int_n, 0);
        wait_ce(1);
        z80_m1_n = 0; z80_iorq_n = 0;
        step();
        check("iack_clr", z80_int_n, 1);
        z80_m1_n = 1; z80_iorq_n = 1;
        SNDON = 0;
        step();
        SNDON = 1;
        step();
        wait_ce(0);
        z80_m1_n = 0; z80_iorq_n = 0;
        step();
        check("iack_noce", z80_int_n, 0);
        z80_m1_n = 1; z80_iorq_n = 1;
        step();
        SNDON = 0;
        wait_ce(1);
        // SNDON was low for the wait, so this is a rising edge coincident with IACK
        SNDON = 1; z80_m1_n = 0; z80_iorq_n = 0;
        step();
        check("set_wins", z80_int_n, 0);
        z80_m1_n = 1; z80_iorq_n = 1;
        step();

        // Asynchronous reset in the middle of a write
        m68k_dout_lo = 8'hC3; SNDDT = 0;
        #2 nRESET = 0;
        #1;
        check_reset_vals("midrst");
        model_reset();
        idle_inputs();
        repeat (2) @(posedge clk_main);
        #1 nRESET = 1;
        step();
        check("post_rst_pend", cmd_pending, 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) SNDDT = ~SNDDT;
            if ($urandom_range(7) == 0) SNDON = ~SNDON;
            if ($urandom_range(3) == 0) z80_cmd_rd_n = ~z80_cmd_rd_n;
            z80_m1_n   = ($urandom_range(2) != 0);
            z80_iorq_n = ($urandom_range(2) != 0);
            m68k_dout_lo = 8'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
